// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC parallel-bus engine: FSM state encoding and transfer direction.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      A_SETUP = 3'd1,
      A_PULSE = 3'd2,
      A_HOLD  = 3'd3,
      D_SETUP = 3'd4,
      D_PULSE = 3'd5,
      D_HOLD  = 3'd6,
      GAP     = 3'd7
   } state_t;

   localparam logic RD = 1'b1;
   localparam logic WR = 1'b0;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times each bus phase; zero flags the last clock of the phase.
module phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// Bus engine for the RTC multiplexed address/data bus: address phase, data phase, recovery gap.
// Pin values are registered from the current state, so the pins trail the FSM by one clock.
module rtc_bus_master
   import rtc_bus_pkg::*;
#(
   parameter int unsigned T_SETUP = 1,
   parameter int unsigned T_PULSE = 2,
   parameter int unsigned T_HOLD  = 1,
   parameter int unsigned T_GAP   = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rd_wr,
   input  logic [7:0] dir,
   input  logic [7:0] dato,
   output logic       busy,
   output logic       done,
   output logic [7:0] dato_rtc,
   output logic       cs_n,
   output logic       a_d,
   output logic       rd_n,
   output logic       wr_n,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   input  logic [7:0] bus_in
);

   state_t           state, next_state, phase_q;
   logic             lat_rd;
   logic [7:0]       lat_dir, lat_dato;
   logic             tmr_load, tmr_zero;
   logic [CNT_W-1:0] tmr_val;
   logic             nxt_cs_n, nxt_a_d, nxt_rd_n, nxt_wr_n, nxt_oe;
   logic [7:0]       nxt_bus_out;

   function automatic logic [CNT_W-1:0] ticks(input int unsigned t);
      return CNT_W'(t - 1);
   endfunction

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      next_state  = state;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      nxt_cs_n    = 1'b1;
      nxt_a_d     = 1'b0;
      nxt_rd_n    = 1'b1;
      nxt_wr_n    = 1'b1;
      nxt_oe      = 1'b0;
      nxt_bus_out = '0;

      case (state)
         IDLE:    if (start)    begin next_state = A_SETUP; tmr_load = 1'b1; tmr_val = ticks(T_SETUP); end
         A_SETUP: if (tmr_zero) begin next_state = A_PULSE; tmr_load = 1'b1; tmr_val = ticks(T_PULSE); end
         A_PULSE: if (tmr_zero) begin next_state = A_HOLD;  tmr_load = 1'b1; tmr_val = ticks(T_HOLD);  end
         A_HOLD:  if (tmr_zero) begin next_state = D_SETUP; tmr_load = 1'b1; tmr_val = ticks(T_SETUP); end
         D_SETUP: if (tmr_zero) begin next_state = D_PULSE; tmr_load = 1'b1; tmr_val = ticks(T_PULSE); end
         D_PULSE: if (tmr_zero) begin next_state = D_HOLD;  tmr_load = 1'b1; tmr_val = ticks(T_HOLD);  end
         D_HOLD:  if (tmr_zero) begin next_state = GAP;     tmr_load = 1'b1; tmr_val = ticks(T_GAP);   end
         GAP:     if (tmr_zero) next_state = IDLE;
         default: next_state = IDLE;
      endcase

      // The address is always strobed with wr_n, whatever the transfer direction.
      if (state inside {A_SETUP, A_PULSE, A_HOLD}) begin
         nxt_cs_n    = 1'b0;
         nxt_oe      = 1'b1;
         nxt_bus_out = lat_dir;
         nxt_wr_n    = (state != A_PULSE);
      end
      if (state inside {D_SETUP, D_PULSE, D_HOLD}) begin
         nxt_cs_n    = 1'b0;
         nxt_a_d     = 1'b1;
         nxt_oe      = (lat_rd != RD);
         nxt_bus_out = (lat_rd == RD) ? 8'h00 : lat_dato;
         if (state == D_PULSE) begin
            if (lat_rd == RD) nxt_rd_n = 1'b0;
            else              nxt_wr_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         phase_q  <= IDLE;
         lat_rd   <= 1'b0;
         lat_dir  <= '0;
         lat_dato <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dato_rtc <= '0;
         cs_n     <= 1'b1;
         a_d      <= 1'b0;
         rd_n     <= 1'b1;
         wr_n     <= 1'b1;
         bus_oe   <= 1'b0;
         bus_out  <= '0;
      end else begin
         state   <= next_state;
         phase_q <= state;
         busy    <= (next_state != IDLE);
         done    <= (state == GAP) && (phase_q == D_HOLD);
         cs_n    <= nxt_cs_n;
         a_d     <= nxt_a_d;
         rd_n    <= nxt_rd_n;
         wr_n    <= nxt_wr_n;
         bus_oe  <= nxt_oe;
         bus_out <= nxt_bus_out;
         if (state == IDLE && start) begin
            lat_rd   <= rd_wr;
            lat_dir  <= dir;
            lat_dato <= dato;
         end
         // Capture on the edge that ends the pin-level read strobe, while rd_n is still low.
         if (lat_rd == RD && phase_q == D_PULSE && state != D_PULSE) dato_rtc <= bus_in;
      end
   end

endmodule

// File: tb/tb_rtc_bus_master.sv
// Self-checking bench for rtc_bus_master: default-timing and swept-timing instances against a phase model.
module tb_rtc_bus_master;

   localparam int SA = 1, PA = 2, HA = 1, GA = 2;
   localparam int SB = 3, PB = 4, HB = 2, GB = 1;
   localparam int IDLE_K = 1 << 20;

   typedef struct packed {
      logic       busy;
      int         k;
      logic       rd;
      logic [7:0] dir;
      logic [7:0] dat;
      logic [7:0] drt;
   } mstate_t;

   typedef struct packed {
      logic       cs_n;
      logic       a_d;
      logic       rd_n;
      logic       wr_n;
      logic       oe;
      logic       done;
      logic       busy;
      logic [7:0] bus_out;
      logic [7:0] drt;
   } outs_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic       start_a, rdwr_a, busy_a, done_a, cs_a, ad_a, rdn_a, wrn_a, oe_a;
   logic [7:0] dir_a, dato_a, drt_a, bo_a, bi_a, rv_a;
   logic       start_b, rdwr_b, busy_b, done_b, cs_b, ad_b, rdn_b, wrn_b, oe_b;
   logic [7:0] dir_b, dato_b, drt_b, bo_b, bi_b, rv_b;
   outs_t      act_a, act_b;

   // Board-level device model: the RTC drives its data only while rd_n is low.
   assign bi_a = rdn_a ? 8'hFF : rv_a;
   assign bi_b = rdn_b ? 8'hFF : rv_b;
   assign act_a = {cs_a, ad_a, rdn_a, wrn_a, oe_a, done_a, busy_a, bo_a, drt_a};
   assign act_b = {cs_b, ad_b, rdn_b, wrn_b, oe_b, done_b, busy_b, bo_b, drt_b};

   always #5 clk = ~clk;

   rtc_bus_master dut_a (
      .clk(clk), .reset(reset), .start(start_a), .rd_wr(rdwr_a), .dir(dir_a), .dato(dato_a),
      .busy(busy_a), .done(done_a), .dato_rtc(drt_a), .cs_n(cs_a), .a_d(ad_a), .rd_n(rdn_a),
      .wr_n(wrn_a), .bus_out(bo_a), .bus_oe(oe_a), .bus_in(bi_a)
   );

   rtc_bus_master #(.T_SETUP(SB), .T_PULSE(PB), .T_HOLD(HB), .T_GAP(GB), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .rd_wr(rdwr_b), .dir(dir_b), .dato(dato_b),
      .busy(busy_b), .done(done_b), .dato_rtc(drt_b), .cs_n(cs_b), .a_d(ad_b), .rd_n(rdn_b),
      .wr_n(wrn_b), .bus_out(bo_b), .bus_oe(oe_b), .bus_in(bi_b)
   );

   function automatic mstate_t mreset();
      mstate_t m;
      m   = '0;
      m.k = IDLE_K;
      return m;
   endfunction

   // k counts clock edges since the accepting edge; the transaction spans 2L+G edges of busy.
   function automatic mstate_t mstep(mstate_t m, logic st, logic rw, logic [7:0] d, logic [7:0] w,
                                     logic [7:0] rv, int s, int p, int h, int g);
      int l;
      mstate_t r;
      r = m;
      l = s + p + h;
      if (r.busy) begin
         r.k = r.k + 1;
         if (r.rd && r.k == l + s + p + 1) r.drt = rv;
         if (r.k == 2 * l + g) r.busy = 1'b0;
      end else if (st) begin
         r.busy = 1'b1;
         r.k    = 0;
         r.rd   = rw;
         r.dir  = d;
         r.dat  = w;
      end else if (r.k < IDLE_K) begin
         r.k = r.k + 1;
      end
      return r;
   endfunction

   // Pins show phase t = k-1: setup/pulse/hold of the address phase, then the same of the data phase.
   function automatic outs_t mexp(mstate_t m, int s, int p, int h);
      outs_t o;
      int    l, t, u;
      logic  dph, stb;
      l = s + p + h;
      o = '0;
      o.cs_n = 1'b1;
      o.rd_n = 1'b1;
      o.wr_n = 1'b1;
      o.busy = m.busy;
      o.drt  = m.drt;
      o.done = (m.k == 2 * l + 1);
      if (m.k >= 1 && m.k <= 2 * l) begin
         t   = m.k - 1;
         dph = (t >= l);
         u   = dph ? t - l : t;
         stb = (u >= s) && (u < s + p);
         o.cs_n = 1'b0;
         o.a_d  = dph;
         if (!dph) begin
            o.oe = 1'b1; o.bus_out = m.dir; o.wr_n = !stb;
         end else if (m.rd) begin
            o.rd_n = !stb;
         end else begin
            o.oe = 1'b1; o.bus_out = m.dat; o.wr_n = !stb;
         end
      end
      return o;
   endfunction

   mstate_t ma = '{busy: 1'b0, k: IDLE_K, rd: 1'b0, dir: 8'h00, dat: 8'h00, drt: 8'h00};
   mstate_t mb = '{busy: 1'b0, k: IDLE_K, rd: 1'b0, dir: 8'h00, dat: 8'h00, drt: 8'h00};

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ma <= mreset();
         mb <= mreset();
      end else begin
         ma <= mstep(ma, start_a, rdwr_a, dir_a, dato_a, rv_a, SA, PA, HA, GA);
         mb <= mstep(mb, start_b, rdwr_b, dir_b, dato_b, rv_b, SB, PB, HB, GB);
      end
   end

   task automatic cmp1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmpi(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string id, input outs_t a, input outs_t e);
      cmp1({id, ".cs_n"}, a.cs_n, e.cs_n);
      cmp1({id, ".a_d"}, a.a_d, e.a_d);
      cmp1({id, ".rd_n"}, a.rd_n, e.rd_n);
      cmp1({id, ".wr_n"}, a.wr_n, e.wr_n);
      cmp1({id, ".bus_oe"}, a.oe, e.oe);
      cmp1({id, ".done"}, a.done, e.done);
      cmp1({id, ".busy"}, a.busy, e.busy);
      cmp8({id, ".bus_out"}, a.bus_out, e.bus_out);
      cmp8({id, ".dato_rtc"}, a.drt, e.drt);
      cmp1({id, ".proto_both_strobes_low"}, !a.rd_n && !a.wr_n, 1'b0);
      cmp1({id, ".proto_strobe_without_cs"}, (!a.rd_n || !a.wr_n) && a.cs_n, 1'b0);
      cmp1({id, ".proto_oe_during_read"}, a.oe && !a.rd_n, 1'b0);
   endtask

   always @(negedge clk) begin
      check_dut("a", act_a, mexp(ma, SA, PA, HA));
      check_dut("b", act_b, mexp(mb, SB, PB, HB));
   end

   task automatic drive(input logic sel, input logic st, input logic rw, input logic [7:0] d,
                        input logic [7:0] w, input logic [7:0] rv);
      if (sel) begin start_b = st; rdwr_b = rw; dir_b = d; dato_b = w; rv_b = rv; end
      else     begin start_a = st; rdwr_a = rw; dir_a = d; dato_a = w; rv_a = rv; end
   endtask

   task automatic run_txn(input logic sel, input logic rw, input logic [7:0] d, input logic [7:0] w,
                          input logic [7:0] rv, output int done_at, output int wa, output int wd,
                          output int rl, output int wdp, output logic [7:0] drt_done);
      outs_t o;
      done_at = -1; wa = 0; wd = 0; rl = 0; wdp = 0; drt_done = 8'hXX;
      drive(sel, 1'b1, rw, d, w, rv);
      @(posedge clk); #1;
      drive(sel, 1'b0, rw, d, w, rv);
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         o = sel ? act_b : act_a;
         if (!o.wr_n && !o.a_d && o.bus_out == d) wa++;
         if (!o.wr_n && o.a_d && o.bus_out == w) wd++;
         if (!o.rd_n) rl++;
         if (!o.wr_n && o.a_d) wdp++;
         if (o.done && done_at < 0) begin done_at = n; drt_done = o.drt; end
         if (!o.busy && done_at > 0) break;
      end
   endtask

   task automatic wait_idle(input logic sel, inout int dones);
      outs_t o;
      logic  ok;
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         o = sel ? act_b : act_a;
         if (o.done) dones++;
         if (!o.busy) begin ok = 1'b1; break; end
      end
      cmp1(sel ? "b.idle_timeout" : "a.idle_timeout", ok, 1'b1);
   endtask

   // Starts offered at edge 3 and in the done cycle are refused; a held start is taken once idle.
   task automatic acc_test(input logic sel, input int exp_done, input int exp_acc);
      outs_t o;
      int    done_at, acc_at, dones, bad;
      done_at = -1; acc_at = -1; dones = 0; bad = 0;
      drive(sel, 1'b1, 1'b0, 8'h30, 8'h31, 8'h00);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 8'h30, 8'h31, 8'h00);
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         o = sel ? act_b : act_a;
         if (n == 2) drive(sel, 1'b1, 1'b0, 8'h99, 8'h99, 8'h00);
         if (n == 3) drive(sel, 1'b0, 1'b0, 8'h30, 8'h31, 8'h00);
         if (!o.wr_n && o.bus_out == 8'h99) bad++;
         if (o.done) dones++;
         if (done_at > 0 && o.busy && n > done_at) begin acc_at = n; break; end
         if (o.done && done_at < 0) begin
            done_at = n;
            drive(sel, 1'b1, 1'b0, 8'h77, 8'h78, 8'h00);
         end
      end
      drive(sel, 1'b0, 1'b0, 8'h77, 8'h78, 8'h00);
      cmpi(sel ? "b.busy_done_edge" : "a.busy_done_edge", done_at, exp_done);
      cmpi(sel ? "b.accept_edge" : "a.accept_edge", acc_at, exp_acc);
      cmpi(sel ? "b.done_count_before_accept" : "a.done_count_before_accept", dones, 1);
      cmpi(sel ? "b.rejected_start_strobes" : "a.rejected_start_strobes", bad, 0);
      wait_idle(sel, dones);
      cmpi(sel ? "b.done_count_total" : "a.done_count_total", dones, 2);
   endtask

   initial begin
      int done_at, wa, wd, rl, wdp, dn;
      logic [7:0] drt;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk); #1;
      cmp8("rst.dato_rtc", drt_a, 8'h00);
      cmp1("rst.cs_n", cs_a, 1'b1);
      cmp1("rst.busy", busy_a, 1'b0);
      cmp1("rst.bus_oe", oe_a, 1'b0);

      run_txn(1'b0, 1'b0, 8'h21, 8'h45, 8'h00, done_at, wa, wd, rl, wdp, drt);
      cmpi("wr.done_edge", done_at, 9);
      cmpi("wr.addr_strobe_cycles", wa, 2);
      cmpi("wr.data_strobe_cycles", wd, 2);
      cmpi("wr.rd_strobe_cycles", rl, 0);
      cmp8("wr.dato_rtc", drt, 8'h00);

      run_txn(1'b0, 1'b1, 8'h22, 8'h00, 8'h37, done_at, wa, wd, rl, wdp, drt);
      cmpi("rd.done_edge", done_at, 9);
      cmpi("rd.addr_strobe_cycles", wa, 2);
      cmpi("rd.rd_strobe_cycles", rl, 2);
      cmpi("rd.data_wr_strobe_cycles", wdp, 0);
      cmp8("rd.dato_rtc", drt, 8'h37);

      acc_test(1'b0, 9, 11);
      cmp8("busy.dato_rtc_kept", drt_a, 8'h37);

      run_txn(1'b1, 1'b0, 8'h5A, 8'hA5, 8'h00, done_at, wa, wd, rl, wdp, drt);
      cmpi("sweep_wr.done_edge", done_at, 19);
      cmpi("sweep_wr.addr_strobe_cycles", wa, 4);
      cmpi("sweep_wr.data_strobe_cycles", wd, 4);
      run_txn(1'b1, 1'b1, 8'h5B, 8'h00, 8'hC3, done_at, wa, wd, rl, wdp, drt);
      cmpi("sweep_rd.done_edge", done_at, 19);
      cmpi("sweep_rd.rd_strobe_cycles", rl, 4);
      cmpi("sweep_rd.data_wr_strobe_cycles", wdp, 0);
      cmp8("sweep_rd.dato_rtc", drt, 8'hC3);
      acc_test(1'b1, 19, 20);

      drive(1'b0, 1'b1, 1'b1, 8'h50, 8'h00, 8'h66);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 8'h50, 8'h00, 8'h66);
      repeat (6) @(posedge clk);
      #1 cmp1("abort.rd_n_low_before_reset", rdn_a, 1'b0);
      #2 reset = 1'b0;
      #1;
      cmp1("abort.cs_n", cs_a, 1'b1);
      cmp1("abort.rd_n", rdn_a, 1'b1);
      cmp1("abort.wr_n", wrn_a, 1'b1);
      cmp1("abort.bus_oe", oe_a, 1'b0);
      cmp8("abort.dato_rtc", drt_a, 8'h00);
      dn = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (done_a) dn++;
      end
      #2 reset = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         if (done_a) dn++;
      end
      cmpi("abort.done_pulses", dn, 0);
      run_txn(1'b0, 1'b0, 8'h61, 8'h62, 8'h00, done_at, wa, wd, rl, wdp, drt);
      cmpi("abort.next_done_edge", done_at, 9);
      cmpi("abort.next_data_strobe_cycles", wd, 2);
      cmp8("abort.next_dato_rtc", drt, 8'h00);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rtc_bus_master.md
Name: rtc_bus_master

Overview:
- Physical-side bus engine for the external RTC's multiplexed 8-bit address/data parallel bus.
- Accepts one transaction request (address, write data, direction) from the read/write control state machine.
- Runs an address phase then a data phase, with programmable setup, strobe and hold timing.
- Returns the read byte on dato_rtc and pulses done. Sits between the control/top level and the board-level tristate buffer.

Parameters:
- T_SETUP, 1, clocks that cs_n and the a_d level are stable before a strobe goes low (≥1).
- T_PULSE, 2, clocks that rd_n or wr_n is held low (≥1).
- T_HOLD, 1, clocks after a strobe rises before the bus or a_d changes (≥1).
- T_GAP, 2, recovery clocks after a transaction before the next start is accepted (≥1).
- CNT_W, 8, width of the phase counter. Every T_* must be < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-clock request strobe; ignored while busy=1.
- rd_wr  in  1  1 = read, 0 = write; sampled with start.
- dir  in  8  RTC register address; sampled with start.
- dato  in  8  write data; sampled with start.
- busy  out  1  transaction in progress, including the gap.
- done  out  1  one-clock pulse at the end of the data phase.
- dato_rtc  out  8  last byte read from the RTC.
- cs_n  out  1  chip select, active low.
- a_d  out  1  0 = address phase, 1 = data phase.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  write strobe, active low.
- bus_out  out  8  value driven onto the AD bus.
- bus_oe  out  1  1 = drive the AD bus (the tristate is at top level).
- bus_in  in  8  AD bus sampled value.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, done=0, dato_rtc=8'h00.
  - cs_n=1, rd_n=1, wr_n=1, a_d=0, bus_oe=0, bus_out=8'h00, internal latches cleared.
  - Reset asserted mid-transaction releases all strobes and bus_oe on the asynchronous edge. The aborted transaction produces no done pulse.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, GAP.
- The counter loads T_x-1 on entry to each timed state. The state advances when the counter reaches 0.
- IDLE: on start=1, latch rd_wr/dir/dato and go to A_SETUP; busy=1 from the next cycle.
- A_SETUP: cs_n=0, a_d=0, bus_oe=1, bus_out=dir.
- A_PULSE: wr_n=0 (the address is always latched with wr_n, regardless of rd_wr).
- A_HOLD: wr_n=1; cs_n=0, bus still driving dir.
- D_SETUP: a_d=1, cs_n=0.
  - Write: bus_oe=1, bus_out=dato.
  - Read: bus_oe=0.
- D_PULSE:
  - Write: wr_n=0.
  - Read: rd_n=0. bus_in is registered into dato_rtc on the last clock edge of D_PULSE, while rd_n is still low.
- D_HOLD: strobes high; bus_oe keeps its write/read value. On exit: done=1 for one cycle, cs_n=1, bus_oe=0.
- GAP: cs_n=1, bus_oe=0, a_d=0. Lasts T_GAP cycles, then go to IDLE with busy=0.
- Latency:
  - done rises 2*(T_SETUP+T_PULSE+T_HOLD)+1 clock edges after the edge that samples start (9 with defaults).
  - The next start is accepted T_GAP cycles after done.
- start while busy: ignored, not queued. start in the same cycle busy falls is ignored; it is accepted only when IDLE and busy=0.
- dato_rtc changes only on a completed read. A write never alters it.
- rd_n and wr_n are never both low. Neither is low while cs_n=1. bus_oe=0 whenever rd_n=0.

Decomposition:
- Shared package rtc_bus_pkg: state encoding constants (3-bit); RD=1'b1 / WR=1'b0 direction constants.
- One natural sub-module: phase_timer (loadable down-counter with a zero flag, width CNT_W), instanced once. Everything else is in the FSM.

Test Plan:
- Write, defaults: start with rd_wr=0, dir=8'h21, dato=8'h45.
  - Required: bus_out=21 while a_d=0 and wr_n is low for 2 cycles; then bus_out=45 while a_d=1 and wr_n is low for 2 cycles; done at edge 9; dato_rtc unchanged.
- Read: start with rd_wr=1, dir=8'h22; bus model drives bus_in=8'h37 while rd_n=0.
  - Required: bus_oe=0 during the data phase; rd_n low for 2 cycles; dato_rtc=37 when done pulses; wr_n stays high in the data phase.
- Busy rejection: second start at cycle 3, and again in the cycle of done.
  - Required: both ignored; exactly one transaction; start is accepted only after busy=0.
- Reset mid-read: reset=0 during D_PULSE.
  - Required: cs_n/rd_n/wr_n=1, bus_oe=0 immediately; no done; dato_rtc=00; after release, a new write completes normally.
- Parameter sweep: T_SETUP=3, T_PULSE=4, T_HOLD=2, T_GAP=1.
  - Required: strobe widths of exactly 4 cycles; done at edge 19; next start accepted 1 cycle after done.
- Protocol assertions on all tests:
  - Never rd_n=0 and wr_n=0 together.
  - Never a strobe low with cs_n=1.
  - Never bus_oe=1 with rd_n=0.
  - a_d stable from the start of setup until the end of hold.
